fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_if.sv | 36 +++
 rtl/fetch_unit.sv | 151 +++++++++++++++
 tb/tb_fetch_unit.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// fetch_unit_if
//   Bundles every non-clock signal of the fetch unit: the PC register link
//   (pc_value / new_pc), the instruction-memory request/ack bus, the redirect
//   input from execute, and the valid/ready output towards decode.
//   master : the fetch unit itself
//   slave  : the environment (PC register, instruction memory, decode, execute)
interface fetch_unit_if #(
    parameter int N = 32
);
    logic [N-1:0] pc_value;
    logic [N-1:0] new_pc;

    logic         imem_req;
    logic [N-1:0] imem_addr;
    logic         imem_ack;
    logic [31:0]  imem_rdata;

    logic         redirect_valid;
    logic [N-1:0] redirect_target;

    logic         instr_valid;
    logic         instr_ready;
    logic [31:0]  instr;
    logic [N-1:0] instr_pc;
    logic [N-1:0] instr_pc_plus4;

    modport master (
        input  pc_value, imem_ack, imem_rdata, redirect_valid, redirect_target, instr_ready,
        output new_pc, imem_req, imem_addr, instr_valid, instr, instr_pc, instr_pc_plus4
    );

    modport slave (
        output pc_value, imem_ack, imem_rdata, redirect_valid, redirect_target, instr_ready,
        input  new_pc, imem_req, imem_addr, instr_valid, instr, instr_pc, instr_pc_plus4
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit
//   Single-outstanding instruction fetcher. Issues one memory request at a
//   time from the current PC, hands the returned word to decode through a
//   valid/ready output register backed by a one-entry skid register, and
//   tells the PC register what to load next (hold, advance by 4, or jump to
//   a redirect target). Responses to requests made on a path that has since
//   been redirected are dropped.
// Ports
//   clk    : clock, all state on its rising edge
//   reset  : asynchronous active-high reset
//   bus    : fetch_unit_if.master (PC link, imem bus, redirect, decode output)
module fetch_unit #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        FULL
    } state_t;

    state_t       state_reg;
    logic         drop_reg;
    logic         imem_req_reg;
    logic [N-1:0] imem_addr_reg;
    logic         instr_valid_reg;
    logic [31:0]  instr_reg;
    logic [N-1:0] instr_pc_reg;
    logic [N-1:0] instr_pc_plus4_reg;
    logic [31:0]  skid_instr_reg;
    logic [N-1:0] skid_pc_reg;

    logic         slot_free;
    logic         fetch_accept;
    logic [N-1:0] addr_plus4;
    logic [N-1:0] skid_plus4;
    logic [N-1:0] new_pc_next;

    // The output register can take a new word if it is empty or being consumed.
    assign slot_free    = !instr_valid_reg || bus.instr_ready;
    // A response is kept (into output or skid) only on the live path.
    assign fetch_accept = (state_reg == WAIT) && bus.imem_ack && !drop_reg && !bus.redirect_valid;
    // Wraps modulo 2^N by construction.
    assign addr_plus4   = imem_addr_reg + N'(4);
    assign skid_plus4   = skid_pc_reg + N'(4);

    // The PC register loads new_pc every cycle, so "hold" means echoing pc_value.
    always_comb begin
        new_pc_next = bus.pc_value;
        if (reset) begin
            new_pc_next = bus.pc_value;
        end else if (bus.redirect_valid) begin
            new_pc_next = bus.redirect_target;
        end else if (fetch_accept) begin
            new_pc_next = addr_plus4;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg          <= IDLE;
            drop_reg           <= 1'b0;
            imem_req_reg       <= 1'b0;
            imem_addr_reg      <= '0;
            instr_valid_reg    <= 1'b0;
            instr_reg          <= '0;
            instr_pc_reg       <= '0;
            instr_pc_plus4_reg <= '0;
            skid_instr_reg     <= '0;
            skid_pc_reg        <= '0;
        end else begin
            // Consumed words retire unless a new word loads on this same edge
            // (the load assignments below take priority).
            if (instr_valid_reg && bus.instr_ready) begin
                instr_valid_reg <= 1'b0;
            end
            // A redirect flushes whatever decode has not yet taken.
            if (bus.redirect_valid) begin
                instr_valid_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (slot_free && !bus.redirect_valid) begin
                        state_reg     <= WAIT;
                        imem_req_reg  <= 1'b1;
                        imem_addr_reg <= bus.pc_value;
                    end else begin
                        imem_req_reg  <= 1'b0;
                    end
                end

                WAIT: begin
                    if (bus.imem_ack) begin
                        imem_req_reg <= 1'b0;
                        state_reg    <= IDLE;
                        if (drop_reg) begin
                            drop_reg <= 1'b0;
                        end else if (bus.redirect_valid) begin
                            // Wrong-path word arriving with the redirect: discard.
                            drop_reg <= 1'b0;
                        end else if (slot_free) begin
                            instr_valid_reg    <= 1'b1;
                            instr_reg          <= bus.imem_rdata;
                            instr_pc_reg       <= imem_addr_reg;
                            instr_pc_plus4_reg <= addr_plus4;
                        end else begin
                            skid_instr_reg <= bus.imem_rdata;
                            skid_pc_reg    <= imem_addr_reg;
                            state_reg      <= FULL;
                        end
                    end else if (bus.redirect_valid) begin
                        // Request is still in flight; remember to throw its data away.
                        drop_reg <= 1'b1;
                    end
                end

                FULL: begin
                    if (bus.redirect_valid) begin
                        state_reg      <= IDLE;
                        skid_instr_reg <= '0;
                        skid_pc_reg    <= '0;
                    end else if (slot_free) begin
                        instr_valid_reg    <= 1'b1;
                        instr_reg          <= skid_instr_reg;
                        instr_pc_reg       <= skid_pc_reg;
                        instr_pc_plus4_reg <= skid_plus4;
                        state_reg          <= IDLE;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.new_pc         = new_pc_next;
    assign bus.imem_req       = imem_req_reg;
    assign bus.imem_addr      = imem_addr_reg;
    assign bus.instr_valid    = instr_valid_reg;
    assign bus.instr          = instr_reg;
    assign bus.instr_pc       = instr_pc_reg;
    assign bus.instr_pc_plus4 = instr_pc_plus4_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
//   Drives fetch_unit with a PC-register model, a randomly delayed memory
//   responder, random decode back-pressure and redirects. Expected new_pc
//   values and the expected program-order instruction stream are queued by
//   the stimulus side; a negedge monitor pops and compares them.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0040_0000;

    logic        clk;
    logic        reset;
    logic [31:0] pc_reg;
    logic        ack;
    logic [31:0] rdata;
    logic        redir;
    logic [31:0] redir_tgt;
    logic        ready;

    int checks = 0;
    int errors = 0;
    int delivered = 0;

    fetch_unit_if #(.N(32)) bus ();

    assign bus.pc_value        = pc_reg;
    assign bus.imem_ack        = ack;
    assign bus.imem_rdata      = rdata;
    assign bus.redirect_valid  = redir;
    assign bus.redirect_target = redir_tgt;
    assign bus.instr_ready     = ready;

    fetch_unit #(.N(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PC register: loads new_pc every cycle.
    always @(posedge clk or posedge reset) begin
        if (reset) pc_reg <= RESET_PC;
        else       pc_reg <= bus.new_pc;
    end

    // Memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'hC3A5_1E0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: %h at %0t", name, act, $time);
        end
    endtask

    // ---------------- scoreboard queues ----------------
    logic [31:0] np_q[$];      // expected new_pc, one per cycle
    logic [31:0] exp_pc_q[$];  // expected program-order addresses of delivered words
    logic [31:0] req_log[$];   // addresses of issued requests

    task automatic restart_stream(input logic [31:0] start);
        exp_pc_q.delete();
        for (int i = 0; i < 512; i++) exp_pc_q.push_back(start + 32'(i * 4));
    endtask

    // ---------------- stimulus / responder state ----------------
    bit          outstanding = 0;
    bit          dirty = 0;
    bit          new_req = 0;
    int          wait_cnt = 0;
    logic [31:0] req_pc = '0;
    bit          redir_pending = 0;
    logic [31:0] redir_pending_tgt = '0;
    int          ack_min = 1;
    int          ack_max = 1;
    int          ready_pct = 100;
    int          redir_pct = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: random redirect; 1: forced redirect to tgt; 2: no redirect, stray ack
    task automatic drive(input int mode, input logic [31:0] tgt);
        logic [31:0] exp_np;
        logic [31:0] t;
        new_req = 0;
        if (redir_pending) begin
            restart_stream(redir_pending_tgt);
            redir_pending = 0;
        end
        if (!reset) begin
            if (bus.imem_req && !outstanding) begin
                outstanding = 1;
                dirty       = 0;
                new_req     = 1;
                req_pc      = pc_reg;
                wait_cnt    = $urandom_range(ack_max, ack_min);
                req_log.push_back(bus.imem_addr);
                chk("req_addr", bus.imem_addr, pc_reg);
            end else if (outstanding) begin
                chk("req_held", 32'(bus.imem_req), 32'd1);
                chk("addr_held", bus.imem_addr, req_pc);
            end
        end
        ack   = 1'b0;
        rdata = $urandom;
        if (mode == 2) begin
            ack = 1'b1;
        end else if (outstanding) begin
            if (wait_cnt == 0) begin
                ack   = 1'b1;
                rdata = mem_word(req_pc);
            end else begin
                wait_cnt--;
            end
        end
        t = {$urandom} & 32'hFFFF_FFFC;
        if ($urandom_range(7) == 0) t = 32'hFFFF_FFF8;
        if (mode == 1) begin
            redir = 1'b1;
            t     = tgt;
        end else if (mode == 0 && $urandom_range(99) < redir_pct) begin
            redir = 1'b1;
        end else begin
            redir = 1'b0;
        end
        redir_tgt = t;
        ready = ($urandom_range(99) < ready_pct);

        if (reset)                            exp_np = pc_reg;
        else if (redir)                       exp_np = t;
        else if (ack && outstanding && !dirty) exp_np = req_pc + 32'd4;
        else                                  exp_np = pc_reg;
        np_q.push_back(exp_np);

        if (redir) begin
            redir_pending     = 1;
            redir_pending_tgt = t;
            if (outstanding && !ack) dirty = 1;
        end
        if (ack) outstanding = 0;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            tick();
            drive(0, '0);
        end
    endtask

    task automatic wait_new_req();
        int n = 0;
        do begin
            tick();
            drive(0, '0);
            n++;
        end while (!new_req && n < 40);
        if (!new_req) begin
            checks++;
            errors++;
            $display("FAIL wait_req: got no request in 40 cycles, required one");
        end
    endtask

    // ---------------- monitor ----------------
    bit          hold_prev = 0;
    logic [31:0] hold_pc;
    logic [31:0] hold_instr;

    always @(negedge clk) begin
        logic [31:0] p;
        if (np_q.size() != 0) chk("new_pc", bus.new_pc, np_q.pop_front());
        if (reset) begin
            chk("rst_valid", 32'(bus.instr_valid), 32'd0);
            chk("rst_req", 32'(bus.imem_req), 32'd0);
            hold_prev = 0;
        end else begin
            if (hold_prev) begin
                chk("hold_valid", 32'(bus.instr_valid), 32'd1);
                chk("hold_pc", bus.instr_pc, hold_pc);
                chk("hold_instr", bus.instr, hold_instr);
            end
            if (bus.instr_valid && bus.instr_ready) begin
                if (exp_pc_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL deliver: got pc %h, required no delivery", bus.instr_pc);
                end else begin
                    p = exp_pc_q.pop_front();
                    chk("instr_pc", bus.instr_pc, p);
                    chk("instr_pc_plus4", bus.instr_pc_plus4, p + 32'd4);
                    chk("instr", bus.instr, mem_word(p));
                    delivered++;
                end
            end
            hold_prev  = bus.instr_valid && !bus.instr_ready && !bus.redirect_valid;
            hold_pc    = bus.instr_pc;
            hold_instr = bus.instr;
        end
    end

    // ---------------- sequence ----------------
    initial begin
        int idx;
        reset = 1'b1; ack = 1'b0; rdata = '0; redir = 1'b0; redir_tgt = '0; ready = 1'b1;
        restart_stream(RESET_PC);
        repeat (3) tick();
        chk("rst_addr", bus.imem_addr, 32'd0);
        chk("rst_instr", bus.instr, 32'd0);
        chk("rst_instr_pc", bus.instr_pc, 32'd0);
        chk("rst_plus4", bus.instr_pc_plus4, 32'd0);
        chk("rst_new_pc", bus.new_pc, RESET_PC);

        // Straight-line fetch, ack one cycle after each request.
        tick();
        reset = 1'b0;
        req_log.delete();
        drive(0, '0);
        run(12);
        if (req_log.size() >= 3) begin
            chk("seq_addr0", req_log[0], 32'h0040_0000);
            chk("seq_addr1", req_log[1], 32'h0040_0004);
            chk("seq_addr2", req_log[2], 32'h0040_0008);
        end else begin
            checks++; errors++;
            $display("FAIL seq_reqs: got %0d requests, required 3", req_log.size());
        end

        // Decode stalls for five cycles; order must survive.
        ready_pct = 0;
        run(5);
        ready_pct = 100;
        run(10);

        // Redirect while waiting, ack two cycles later -> dropped.
        ack_min = 3; ack_max = 3;
        wait_new_req();
        tick();
        drive(1, 32'h0040_0100);
        idx = req_log.size();
        run(12);
        if (req_log.size() > idx) chk("redir_addr", req_log[idx], 32'h0040_0100);
        else begin
            checks++; errors++;
            $display("FAIL redir_addr: got no request after redirect, required 00400100");
        end

        // Redirect coinciding with the ack.
        ack_min = 2; ack_max = 2;
        wait_new_req();
        tick();
        drive(0, '0);
        tick();
        drive(1, 32'h0040_0200);
        run(10);

        // Address wrap at the top of the space.
        ack_min = 1; ack_max = 1;
        tick();
        drive(1, 32'hFFFF_FFFC);
        run(12);

        // Random traffic.
        ack_min = 1; ack_max = 3; ready_pct = 70; redir_pct = 8;
        run(1500);
        redir_pct = 0; ready_pct = 100;
        run(10);

        // Reset in the middle of a request, then a stray ack.
        ack_min = 3; ack_max = 3;
        wait_new_req();
        tick();
        reset = 1'b1;
        #1;
        chk("arst_req", 32'(bus.imem_req), 32'd0);
        chk("arst_addr", bus.imem_addr, 32'd0);
        chk("arst_valid", 32'(bus.instr_valid), 32'd0);
        chk("arst_instr", bus.instr, 32'd0);
        chk("arst_pc", bus.instr_pc, 32'd0);
        chk("arst_plus4", bus.instr_pc_plus4, 32'd0);
        outstanding = 0; dirty = 0; redir_pending = 0;
        restart_stream(RESET_PC);
        drive(0, '0);
        tick();
        drive(0, '0);
        tick();
        reset = 1'b0;
        drive(2, '0);
        ack_min = 1; ack_max = 2;
        run(20);

        checks++;
        if (delivered < 20) begin
            errors++;
            $display("FAIL delivered: got %0d words, required at least 20", delivered);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
